bk_sector_seq: RTL and testbench
================================

Name: bk_sector_seq

Overview:
Backup-RAM sector sequencer. Moves the NVRAM image between the on-chip backup RAM and the mounted save file, one 512-byte sector per hps_io sd_rd/sd_wr handshake. It is the parametrised successor of the fixed 64-sector load/save loop in the emu top. New over that loop: a configurable sector count, clamping of loads to the mounted image size, and a busy-safe request policy. Instantiated in the emu top between hps_io and the NVRAM dual-port RAM.

Parameters:
SEC_W, 6, log2 of the maximum sector count; max image = 2^SEC_W x 512 bytes.
LBA_W, 32, width of sd_lba.

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high; RESET|status[0] only, never bk_loading
bk_ena  in  1  save file mounted and writable
img_size  in  64  mounted image size in bytes
dl_end  in  1  one-cycle pulse at the falling edge of ioctl_download (autoload trigger)
load_req  in  1  level, OSD load; rising edge triggers
save_req  in  1  level, OSD save; rising edge triggers
sd_ack  in  1  hps_io sector acknowledge
nvram_we  in  1  core write strobe into backup RAM (dirty tracking)
osd_status  in  1  OSD open level
sd_lba  out  LBA_W  current sector
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_loading  out  1  load in progress; feeds core reset
bk_state  out  1  transfer in progress; drives LED_USER
sec_addr  out  SEC_W  sd_lba[SEC_W-1:0], for the NVRAM port-B address

Behaviour:
- Reset, synchronous active-high: all outputs 0; state IDLE; edge registers cleared; dirty=0.
- Edge detection on load_req&bk_ena and save_req&bk_ena uses registered copies. Edges and dl_end arriving outside IDLE are dropped, not queued.
- State IDLE:
  - Load edge, or dl_end&bk_ena&(img_size!=0): go to REQ with load=1. Load wins if load and save trigger in the same cycle.
  - Otherwise, save edge: go to REQ with load=0.
  - On entering REQ: sd_lba=0, last=sec_cnt-1, bk_state=1, bk_loading=load.
- sec_cnt:
  - Save: always 2^SEC_W.
  - Load: ceil(img_size/512), clamped to [1, 2^SEC_W]. Computed as img_size[63:9] + |img_size[8:0], saturating. img_size=0 via the OSD path loads 1 sector.
- State REQ: sd_rd=load, sd_wr=~load in the cycle after entry. Go to WACK.
- State WACK: on rising sd_ack, sd_rd=sd_wr=0 (same edge register). Go to WDONE.
- State WDONE, on falling sd_ack:
  - If sd_lba==last: go to IDLE; bk_state=0, bk_loading=0. On a save, clear dirty.
  - Else: sd_lba+1, re-assert the request in the next cycle; go to WACK.
- Latency: request asserts 1 cycle after the trigger edge. Next request asserts 1 cycle after the sd_ack fall.
- sd_ack already high at trigger: wait for a full low-high-low cycle. The request is not cleared by a stale high.
- reset mid-transfer: immediate IDLE, requests dropped, sd_lba=0. The partially written file is not repaired.
- bk_ena falling mid-transfer: transfer completes; no effect on the sequence.
- sd_lba upper bits beyond SEC_W stay 0.

Optional Feature:
Macro BK_AUTOSAVE_EN.
- Defined:
  - dirty is set by nvram_we while not loading.
  - Rising edge of osd_status with dirty&bk_ena&IDLE starts a save as if save_req rose.
  - A completed load clears dirty.
- Not defined: osd_status and nvram_we are ignored (ports kept), and dirty is constant 0.

Decomposition:
- Package bk_pkg: state enum (IDLE, REQ, WACK, WDONE), localparam SECTOR_BYTES=512, and function sec_count(img_size, SEC_W) implementing the clamp.
- No sub-module. An edge-detect helper would be thinner than a line of logic, so it stays inline.

Test Plan:
1. SEC_W=6, save_req 0->1 with bk_ena=1, BFM acks each request -> 64 sd_wr pulses, sd_lba 0..63, bk_state falls after the 64th ack fall, sd_rd never high.
2. img_size=1000, dl_end pulse -> 2 reads (lba 0,1), bk_loading high throughout, then 0. img_size=0 on dl_end -> no transfer.
3. img_size=1 MiB, load edge -> clamped to 64 reads. Same-cycle load and save edges -> reads only.
4. Save edge at sector 5 of a load -> ignored, load finishes 64 sectors. Reset at sector 10 -> sd_rd=0, sd_lba=0, bk_state=0 the next cycle.
5. sd_ack held high at trigger -> no lba advance until ack falls, rises and falls again.
6. BK_AUTOSAVE_EN: nvram_we pulse, then osd_status rise -> 64-sector save. Second osd_status rise without a write -> no transfer.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared types and helpers for the backup-RAM sector sequencer.
package bk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWack,
    StWdone
  } bk_state_e;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SectorShift  = $clog2(SECTOR_BYTES);

  // Sectors needed to hold an image of `size` bytes, rounded up and clamped to [1, 2^sec_w].
  function automatic logic [63:0] sec_count(input logic [63:0] size, input int unsigned sec_w);
    logic [63:0] cnt;
    logic [63:0] max_cnt;
    cnt     = (size >> SectorShift) + 64'(|(size & 64'(SECTOR_BYTES - 1)));
    max_cnt = 64'd1 << sec_w;
    if (cnt == '0) begin
      cnt = 64'd1;
    end else if (cnt > max_cnt) begin
      cnt = max_cnt;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bk_sector_seq.sv
// Backup-RAM sector sequencer: streams the NVRAM image between backup RAM and the mounted
// save file, one 512-byte sector per sd_rd/sd_wr handshake with hps_io.
// Optional autosave-on-OSD-open is enabled by defining BK_AUTOSAVE_EN.
module bk_sector_seq
  import bk_pkg::*;
#(
  parameter int unsigned SEC_W = 6,
  parameter int unsigned LBA_W = 32
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             bk_ena,
  input  logic [63:0]      img_size,
  input  logic             dl_end,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             sd_ack,
  input  logic             nvram_we,
  input  logic             osd_status,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             bk_loading,
  output logic             bk_state,
  output logic [SEC_W-1:0] sec_addr
);

  localparam int unsigned CntW = SEC_W + 1;

  bk_state_e        state_q;
  logic             load_q;
  logic [SEC_W-1:0] lba_q;
  logic [SEC_W-1:0] last_q;
  logic             sd_rd_q;
  logic             sd_wr_q;
  logic             bk_loading_q;
  logic             bk_state_q;
  logic             load_lvl_q;
  logic             save_lvl_q;
  logic             ack_q;

  logic             load_lvl;
  logic             save_lvl;
  logic             load_trig;
  logic             save_trig;
  logic             ack_rise;
  logic             ack_fall;
  logic [CntW-1:0]  ld_cnt;
  logic [SEC_W-1:0] ld_last;

`ifdef BK_AUTOSAVE_EN
  logic dirty_q;
  logic osd_q;
`else
  // Autosave inputs have no function in this build.
  logic unused_autosave;
  assign unused_autosave = osd_status ^ nvram_we;
`endif

  // Trigger and handshake edge decode against the registered copies.
  always_comb begin
    load_lvl  = load_req & bk_ena;
    save_lvl  = save_req & bk_ena;
    load_trig = (load_lvl & ~load_lvl_q) | (dl_end & bk_ena & (img_size != '0));
    save_trig = save_lvl & ~save_lvl_q;
`ifdef BK_AUTOSAVE_EN
    save_trig = save_trig | (osd_status & ~osd_q & dirty_q & bk_ena);
`endif
    ack_rise  = sd_ack & ~ack_q;
    ack_fall  = ~sd_ack & ack_q;
    ld_cnt    = CntW'(sec_count(img_size, SEC_W));
    ld_last   = SEC_W'(ld_cnt - CntW'(1));
  end

  // Sequencer FSM with registered request, status and edge-history outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StIdle;
      load_q       <= 1'b0;
      lba_q        <= '0;
      last_q       <= '0;
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
      bk_loading_q <= 1'b0;
      bk_state_q   <= 1'b0;
      load_lvl_q   <= 1'b0;
      save_lvl_q   <= 1'b0;
      ack_q        <= 1'b0;
`ifdef BK_AUTOSAVE_EN
      dirty_q      <= 1'b0;
      osd_q        <= 1'b0;
`endif
    end else begin
      // History always tracks, so edges seen while busy are consumed rather than queued.
      load_lvl_q <= load_lvl;
      save_lvl_q <= save_lvl;
      ack_q      <= sd_ack;
`ifdef BK_AUTOSAVE_EN
      osd_q      <= osd_status;
`endif
      unique case (state_q)
        StIdle: begin
          if (load_trig) begin
            state_q      <= StReq;
            load_q       <= 1'b1;
            lba_q        <= '0;
            last_q       <= ld_last;
            bk_state_q   <= 1'b1;
            bk_loading_q <= 1'b1;
          end else if (save_trig) begin
            state_q      <= StReq;
            load_q       <= 1'b0;
            lba_q        <= '0;
            last_q       <= '1;
            bk_state_q   <= 1'b1;
            bk_loading_q <= 1'b0;
          end
        end
        StReq: begin
          sd_rd_q <= load_q;
          sd_wr_q <= ~load_q;
          state_q <= StWack;
        end
        StWack: begin
          // A stale high ack at trigger time is not a rise; wait for a fresh one.
          if (ack_rise) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= StWdone;
          end
        end
        StWdone: begin
          if (ack_fall) begin
            if (lba_q == last_q) begin
              state_q      <= StIdle;
              bk_state_q   <= 1'b0;
              bk_loading_q <= 1'b0;
`ifdef BK_AUTOSAVE_EN
              // Image and RAM agree after either direction completes.
              dirty_q      <= 1'b0;
`endif
            end else begin
              lba_q   <= lba_q + SEC_W'(1);
              sd_rd_q <= load_q;
              sd_wr_q <= ~load_q;
              state_q <= StWack;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef BK_AUTOSAVE_EN
      // Core writes are ignored during a load: those are the loader filling RAM.
      if (nvram_we && !bk_loading_q) begin
        dirty_q <= 1'b1;
      end
`endif
    end
  end

  assign sd_lba     = LBA_W'(lba_q);
  assign sec_addr   = lba_q;
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign bk_loading = bk_loading_q;
  assign bk_state   = bk_state_q;

endmodule

// File: tb/tb_bk_sector_seq.sv
// Self-checking bench for bk_sector_seq: randomized hps_io ack BFM, transaction-level model.
module tb_bk_sector_seq;

  localparam int unsigned SEC_W   = 6;
  localparam int unsigned LBA_W   = 32;
  localparam int          MAX_SEC = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             bk_ena;
  logic [63:0]      img_size;
  logic             dl_end;
  logic             load_req;
  logic             save_req;
  wire              sd_ack;
  logic             nvram_we;
  logic             osd_status;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             bk_loading;
  logic             bk_state;
  logic [SEC_W-1:0] sec_addr;

  logic bfm_en;
  logic bfm_ack;
  logic man_ack;
  assign sd_ack = bfm_en ? bfm_ack : man_ack;

  int checks   = 0;
  int failures = 0;

  // Model of the transfer in flight.
  bit exp_load;
  int exp_cnt;
  int seen;

  always #5 clk = ~clk;

  bk_sector_seq #(
    .SEC_W(SEC_W),
    .LBA_W(LBA_W)
  ) dut (
    .clk_sys   (clk),
    .reset     (reset),
    .bk_ena    (bk_ena),
    .img_size  (img_size),
    .dl_end    (dl_end),
    .load_req  (load_req),
    .save_req  (save_req),
    .sd_ack    (sd_ack),
    .nvram_we  (nvram_we),
    .osd_status(osd_status),
    .sd_lba    (sd_lba),
    .sd_rd     (sd_rd),
    .sd_wr     (sd_wr),
    .bk_loading(bk_loading),
    .bk_state  (bk_state),
    .sec_addr  (sec_addr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sectors a transfer must cover: saves are full size, loads round the image up to sectors.
  function automatic int model_count(input logic [63:0] sz, input bit is_load);
    logic [63:0] n;
    if (!is_load) return MAX_SEC;
    n = sz / 64'd512;
    if (sz % 64'd512 != 0) n = n + 64'd1;
    if (n == 0) n = 64'd1;
    if (n > MAX_SEC) n = MAX_SEC;
    return int'(n);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // kind: 0 save edge, 1 load edge, 2 dl_end, 3 osd open, 4 load+save same cycle
  task automatic start(input int kind, input logic [63:0] sz);
    img_size = sz;
    exp_load = (kind == 1 || kind == 2 || kind == 4);
    exp_cnt  = model_count(sz, exp_load);
    seen     = 0;
    case (kind)
      0:       save_req = 1'b1;
      1:       load_req = 1'b1;
      2:       dl_end = 1'b1;
      3:       osd_status = 1'b1;
      default: begin
        load_req = 1'b1;
        save_req = 1'b1;
      end
    endcase
    tick();
    save_req   = 1'b0;
    load_req   = 1'b0;
    dl_end     = 1'b0;
    osd_status = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input bit drop_ena);
    int n = 0;
    while (bk_state !== 1'b0 && n < 4000) begin
      check({nm, "_loading"}, 64'(bk_loading), 64'(exp_load));
      if (drop_ena && seen >= 3) bk_ena = 1'b0;
      tick();
      n++;
    end
    check({nm, "_timeout"}, 64'(n < 4000), 64'd1);
    check({nm, "_count"}, 64'(seen), 64'(exp_cnt));
    check({nm, "_loading_end"}, 64'(bk_loading), 64'd0);
    bk_ena = 1'b1;
    tick();
  endtask

  // Monitor plus ack BFM: checks every request against the model, then acknowledges it.
  initial begin
    bit prev_req = 1'b0;
    int phase    = 0;
    int dly      = 0;
    int hold     = 0;
    bfm_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prev_req = 1'b0;
        phase    = 0;
        bfm_ack  = 1'b0;
      end else begin
        check("lba_upper_zero", 64'(sd_lba >> SEC_W), 64'd0);
        check("rd_wr_exclusive", 64'(sd_rd & sd_wr), 64'd0);
        check("loading_implies_busy", 64'(bk_loading & ~bk_state), 64'd0);
        if ((sd_rd | sd_wr) && !prev_req) begin
          check("req_kind", 64'(sd_rd), 64'(exp_load));
          check("req_lba", 64'(sd_lba), 64'(seen));
          seen++;
        end
        if (sd_rd | sd_wr) begin
          check("req_busy", 64'(bk_state), 64'd1);
          check("req_sec_addr", 64'(sec_addr), 64'((seen - 1) % MAX_SEC));
        end
        prev_req = sd_rd | sd_wr;
        if (bfm_en) begin
          case (phase)
            0: if (sd_rd | sd_wr) begin
              dly   = $urandom_range(0, 3);
              phase = 1;
            end
            1: if (dly == 0) begin
              bfm_ack = 1'b1;
              hold    = $urandom_range(0, 4);
              phase   = 2;
            end else begin
              dly--;
            end
            default: begin
              check("ack_clears_req", 64'(sd_rd | sd_wr), 64'd0);
              if (hold == 0) begin
                bfm_ack = 1'b0;
                phase   = 0;
              end else begin
                hold--;
              end
            end
          endcase
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; bk_ena = 1'b0; img_size = '0; dl_end = 1'b0; load_req = 1'b0;
    save_req = 1'b0; nvram_we = 1'b0; osd_status = 1'b0; man_ack = 1'b0; bfm_en = 1'b1;
    exp_load = 1'b0; exp_cnt = 0; seen = 0;
    repeat (3) tick();
    check("rst_sd_rd", 64'(sd_rd), 64'd0);
    check("rst_sd_wr", 64'(sd_wr), 64'd0);
    check("rst_sd_lba", 64'(sd_lba), 64'd0);
    check("rst_bk_state", 64'(bk_state), 64'd0);
    check("rst_bk_loading", 64'(bk_loading), 64'd0);
    check("rst_sec_addr", 64'(sec_addr), 64'd0);
    reset = 1'b0; bk_ena = 1'b1;
    tick();

    // Pin the model against hand-computed sector counts.
    check("model_1000", 64'(model_count(64'd1000, 1'b1)), 64'd2);
    check("model_1mib", 64'(model_count(64'd1048576, 1'b1)), 64'd64);
    check("model_zero", 64'(model_count(64'd0, 1'b1)), 64'd1);
    check("model_512", 64'(model_count(64'd512, 1'b1)), 64'd1);
    check("model_513", 64'(model_count(64'd513, 1'b1)), 64'd2);
    check("model_save", 64'(model_count(64'd1000, 1'b0)), 64'd64);

    // 1: full save, with trigger-to-request latency.
    start(0, 64'd1000);
    check("t1_busy_after_trig", 64'(bk_state), 64'd1);
    check("t1_no_req_yet", 64'(sd_wr), 64'd0);
    tick();
    check("t1_req_latency", 64'(sd_wr), 64'd1);
    check("t1_lba0", 64'(sd_lba), 64'd0);
    wait_idle("t1_save", 1'b0);

    // 2: autoload of a 1000-byte image, then dl_end with empty image.
    start(2, 64'd1000);
    check("t2_loading", 64'(bk_loading), 64'd1);
    wait_idle("t2_dl_load", 1'b0);
    img_size = 64'd0; exp_cnt = 0; seen = 0;
    dl_end = 1'b1;
    tick();
    dl_end = 1'b0;
    repeat (6) tick();
    check("t2_empty_idle", 64'(bk_state), 64'd0);
    check("t2_empty_reqs", 64'(seen), 64'd0);

    // 3: oversized image clamps; simultaneous load and save picks load.
    start(1, 64'd1048576);
    wait_idle("t3_clamp", 1'b0);
    start(4, 64'd1000);
    wait_idle("t3_both", 1'b0);

    // 4: save edge during a load is dropped; reset mid-transfer aborts.
    start(1, 64'd1048576);
    n = 0;
    while (seen < 6 && n < 500) begin tick(); n++; end
    check("t4_reach5", 64'(seen >= 6), 64'd1);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    wait_idle("t4_ignore_save", 1'b0);
    repeat (4) tick();
    check("t4_no_late_save", 64'(bk_state), 64'd0);
    start(1, 64'd1048576);
    n = 0;
    while (seen < 11 && n < 500) begin tick(); n++; end
    check("t4_reach10", 64'(seen >= 11), 64'd1);
    reset = 1'b1;
    tick();
    check("t4_rst_rd", 64'(sd_rd), 64'd0);
    check("t4_rst_lba", 64'(sd_lba), 64'd0);
    check("t4_rst_state", 64'(bk_state), 64'd0);
    check("t4_rst_loading", 64'(bk_loading), 64'd0);
    reset = 1'b0;
    repeat (2) tick();

    // 5: ack already high at trigger needs a full low-high-low before advancing.
    bfm_en = 1'b0; man_ack = 1'b1;
    tick();
    start(0, 64'd0);
    repeat (3) tick();
    check("t5_stale_req", 64'(sd_wr), 64'd1);
    check("t5_stale_lba", 64'(sd_lba), 64'd0);
    man_ack = 1'b0;
    repeat (2) tick();
    check("t5_low_req", 64'(sd_wr), 64'd1);
    man_ack = 1'b1;
    tick();
    check("t5_rise_clears", 64'(sd_wr), 64'd0);
    check("t5_rise_lba", 64'(sd_lba), 64'd0);
    tick();
    man_ack = 1'b0;
    tick();
    check("t5_fall_lba", 64'(sd_lba), 64'd1);
    check("t5_fall_req", 64'(sd_wr), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; bfm_en = 1'b1;
    repeat (2) tick();

`ifdef BK_AUTOSAVE_EN
    // 6: a core write marks dirty; OSD open then saves once.
    nvram_we = 1'b1;
    tick();
    nvram_we = 1'b0;
    tick();
    start(3, 64'd0);
    wait_idle("t6_autosave", 1'b0);
    exp_cnt = 0; seen = 0;
    osd_status = 1'b1;
    tick();
    osd_status = 1'b0;
    repeat (6) tick();
    check("t6_clean_idle", 64'(bk_state), 64'd0);
    check("t6_clean_reqs", 64'(seen), 64'd0);
`endif

    // Random transfers, some losing bk_ena part-way through.
    for (int i = 0; i < 8; i++) begin
      int          kind;
      int          pick;
      logic [63:0] sz;
      kind = $urandom_range(0, 2);
      pick = $urandom_range(0, 3);
      case (pick)
        0:       sz = 64'($urandom_range(1, 600));
        1:       sz = 64'($urandom_range(0, 40000));
        2:       sz = {32'($urandom), 32'($urandom)};
        default: sz = 64'd32768 + 64'($urandom_range(0, 1));
      endcase
      if (kind == 2 && sz == 0) sz = 64'd512;
      repeat ($urandom_range(0, 3)) tick();
      start(kind, sz);
      wait_idle("rand", 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
